biriscv_fetch_issue: RTL

BIRISCV_FETCH_ISSUE -- requirements
Module: biriscv_fetch_issue

---
 rtl/biriscv_fetch_issue.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/biriscv_fetch_issue.sv
// Instruction fetch issue stage. It keeps at most one I-cache request in flight and skid-buffers
// the response while decode stalls. Redirects flush the stage, and faulted packets halt fetch.
module biriscv_fetch_issue #(
    parameter logic [31:0] BOOT_VECTOR = 32'h80000000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        branch_request_i,
    input  logic [31:0] branch_pc_i,
    input  logic [1:0]  branch_priv_i,
    output logic        icache_rd_o,
    output logic [31:0] icache_pc_o,
    output logic [1:0]  icache_priv_o,
    input  logic        icache_accept_i,
    input  logic        icache_valid_i,
    input  logic [63:0] icache_inst_i,
    input  logic        icache_error_i,
    input  logic        icache_page_fault_i,
    output logic        fetch_valid_o,
    output logic [63:0] fetch_instr_o,
    output logic [31:0] fetch_pc_o,
    output logic [1:0]  fetch_pred_branch_o,
    output logic        fetch_fault_fetch_o,
    output logic        fetch_fault_page_o,
    input  logic        fetch_accept_i
);

    typedef enum logic [1:0] {S_RUN, S_WAIT, S_HOLD} state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_req_pc;
    logic [1:0]  r_priv;
    logic        r_discard;
    logic        r_halt;
    logic [63:0] r_skid_instr;
    logic [31:0] r_skid_pc;
    logic        r_skid_err;
    logic        r_skid_pf;

    logic        w_req_fire;
    logic        w_resp_live;
    logic        w_resp_fault;
    logic [63:0] w_resp_instr;
    logic        w_unused_branch_lsbs;

    assign w_unused_branch_lsbs = ^branch_pc_i[2:0];

    assign w_req_fire   = icache_rd_o & icache_accept_i;
    assign w_resp_live  = (r_state == S_WAIT) & icache_valid_i & ~r_discard & ~branch_request_i;
    assign w_resp_fault = icache_error_i | icache_page_fault_i;
    assign w_resp_instr = w_resp_fault ? 64'b0 : icache_inst_i;

    // A live response bypasses the skid register. A redirect suppresses any packet that cycle.
    always_comb begin
        icache_rd_o         = ~rst_i & (r_state == S_RUN) & ~r_halt;
        icache_pc_o         = r_pc;
        icache_priv_o       = r_priv;
        fetch_valid_o       = 1'b0;
        fetch_instr_o       = 64'b0;
        fetch_pc_o          = 32'b0;
        fetch_pred_branch_o = 2'b00;
        fetch_fault_fetch_o = 1'b0;
        fetch_fault_page_o  = 1'b0;
        if (w_resp_live) begin
            fetch_valid_o       = 1'b1;
            fetch_instr_o       = w_resp_instr;
            fetch_pc_o          = r_req_pc;
            fetch_fault_fetch_o = icache_error_i;
            fetch_fault_page_o  = icache_page_fault_i;
        end else if ((r_state == S_HOLD) && !branch_request_i) begin
            fetch_valid_o       = 1'b1;
            fetch_instr_o       = r_skid_instr;
            fetch_pc_o          = r_skid_pc;
            fetch_fault_fetch_o = r_skid_err;
            fetch_fault_page_o  = r_skid_pf;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= S_RUN;
            r_pc         <= BOOT_VECTOR;
            r_req_pc     <= BOOT_VECTOR;
            r_priv       <= 2'b11;
            r_discard    <= 1'b0;
            r_halt       <= 1'b0;
            r_skid_instr <= 64'b0;
            r_skid_pc    <= 32'b0;
            r_skid_err   <= 1'b0;
            r_skid_pf    <= 1'b0;
        end else if (branch_request_i) begin
            r_pc         <= {branch_pc_i[31:3], 3'b000};
            r_priv       <= branch_priv_i;
            r_halt       <= 1'b0;
            r_skid_instr <= 64'b0;
            r_skid_pc    <= 32'b0;
            r_skid_err   <= 1'b0;
            r_skid_pf    <= 1'b0;
            // The request still in flight must have its response dropped when it returns.
            case (r_state)
                S_WAIT: begin
                    if (icache_valid_i) begin
                        r_state   <= S_RUN;
                        r_discard <= 1'b0;
                    end else begin
                        r_discard <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_req_fire) begin
                        r_state   <= S_WAIT;
                        r_discard <= 1'b1;
                    end
                end
                default: r_state <= S_RUN;
            endcase
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_req_fire) begin
                        r_state  <= S_WAIT;
                        r_req_pc <= r_pc;
                        r_pc     <= r_pc + 32'd8;
                    end
                end
                S_WAIT: begin
                    if (icache_valid_i) begin
                        if (r_discard) begin
                            r_discard <= 1'b0;
                            r_state   <= S_RUN;
                        end else if (fetch_accept_i) begin
                            r_state <= S_RUN;
                            r_halt  <= w_resp_fault;
                        end else begin
                            r_state      <= S_HOLD;
                            r_skid_instr <= w_resp_instr;
                            r_skid_pc    <= r_req_pc;
                            r_skid_err   <= icache_error_i;
                            r_skid_pf    <= icache_page_fault_i;
                        end
                    end
                end
                S_HOLD: begin
                    if (fetch_accept_i) begin
                        r_state <= S_RUN;
                        r_halt  <= r_skid_err | r_skid_pf;
                    end
                end
                default: r_state <= S_RUN;
            endcase
        end
    end

endmodule
